// File: rtl/lsu_if.sv
// Core-side request/response handshake and data-memory port bundle for the load/store unit.
// master drives requests and memory read data; slave is the load_store_unit side.
interface lsu_if #(parameter int ADDR_W = 5);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_r_addr, mem_w_addr, mem_data_in
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_r_addr, mem_w_addr, mem_data_in
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word loads with extension, sub-word stores by read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses instead of force-aligning them.
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              req_bad;
  logic              misalign;
  logic [1:0]        req_off;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] off, input logic [2:0] f3);
    logic [4:0] sh;
    sh = {off, 3'b000};
    if (f3[1:0] == 2'd0)
      return (word & ~(32'h0000_00FF << sh)) | ({24'd0, wdata[7:0]} << sh);
    else
      return (word & ~(32'h0000_FFFF << sh)) | ({16'd0, wdata[15:0]} << sh);
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                    ((bus.req_funct3 == 3'd2) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_bad = (bus.req_funct3 == 3'd3) || (bus.req_funct3[2:1] == 2'b11) ||
                   (bus.req_funct3[2] && bus.req_we) || misalign;

  // Lane offset after forced alignment: halves drop bit 0, words use lane 0
  always_comb begin
    req_off = bus.req_addr[1:0];
    if (bus.req_funct3[1:0] == 2'd1) req_off = {bus.req_addr[1], 1'b0};
    if (bus.req_funct3[1:0] == 2'd2) req_off = 2'b00;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (req_bad)                                  state_nxt = RESP;
          else if (bus.req_we && bus.req_funct3 == 3'd2) state_nxt = WR;
          else                                          state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_r_addr  <= '0;
      bus.mem_w_addr  <= '0;
      bus.mem_data_in <= '0;
    end else begin
      state          <= state_nxt;
      bus.req_ready  <= (state_nxt == IDLE);
      bus.resp_valid <= (state_nxt == RESP);
      bus.mem_read   <= (state_nxt == RD);
      bus.mem_write  <= (state_nxt == WR);
      if (accept) begin
        bus.mem_r_addr <= bus.req_addr[ADDR_W+1:2];
        bus.mem_w_addr <= bus.req_addr[ADDR_W+1:2];
        bus.resp_err   <= req_bad;
        bus.resp_rdata <= '0;
        if (bus.req_we && bus.req_funct3 == 3'd2) bus.mem_data_in <= bus.req_wdata;
      end
      if (state == CAP) begin
        if (we_q) bus.mem_data_in <= store_merge(bus.mem_data_out, wdata_q, off_q, funct3_q);
        else      bus.resp_rdata  <= load_extend(bus.mem_data_out, off_q, funct3_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      off_q    <= req_off;
      wdata_q  <= bus.req_wdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array dmem model and a response scoreboard.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic [4:0]  last_waddr;
  logic [31:0] last_wdata;
  logic [31:0] mem [32];
  sb_t  sb_q [$];

  lsu_if #(.ADDR_W(5)) bus ();

  load_store_unit #(.ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // dmem model: registered read, write on strobe
  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_w_addr] <= bus.mem_data_in;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= bus.mem_w_addr;
      last_wdata <= bus.mem_data_in;
    end
    if (bus.mem_read) begin
      bus.mem_data_out <= mem[bus.mem_r_addr];
      rd_cnt <= rd_cnt + 1;
    end
    if (!rst) begin
      checks++;
      assert (!(bus.mem_read && bus.mem_write)) else begin
        errors++;
        $error("FAIL strobe_overlap: read=%0b write=%0b expected not both", bus.mem_read, bus.mem_write);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int exp_rd,
                        input int exp_wr, input int hold, input string tag);
    sb_t e;
    int  cnt;
    int  rd0, wr0;
    logic [31:0] held;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.rd = exp_rd; e.wr = exp_wr;
    sb_q.push_back(e);
    chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.resp_valid && cnt < 20);
    e = sb_q.pop_front();
    chk({tag, "_latency"}, cnt, e.lat);
    chk({tag, "_rdata"}, bus.resp_rdata, e.rdata);
    chk({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
    chk({tag, "_reads"}, rd_cnt - rd0, e.rd);
    chk({tag, "_writes"}, wr_cnt - wr0, e.wr);
    if (hold > 0) begin
      held = bus.resp_rdata;
      bus.resp_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        chk({tag, "_hold_rdata"}, bus.resp_rdata, held);
        chk({tag, "_hold_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
      end
      bus.resp_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_done_valid"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    chk("rst_addrs", {22'd0, bus.mem_r_addr, bus.mem_w_addr}, 32'd0);
    chk("rst_data_in", bus.mem_data_in, 32'd0);
    rst = 1'b0;

    access(1, 3'd2, 32'h04, 32'h12345678, 32'd0, 0, 2, 0, 1, 0, "sw_w1");
    chk("sw_w1_waddr", {27'd0, last_waddr}, 32'd1);
    chk("sw_w1_wdata", last_wdata, 32'h12345678);
    access(1, 3'd2, 32'h00, 32'hCAFEF00D, 32'd0, 0, 2, 0, 1, 0, "sw_w0");
    access(0, 3'd0, 32'h07, 32'd0, 32'h00000012, 0, 3, 1, 0, 0, "lb_07");
    access(0, 3'd1, 32'h06, 32'd0, 32'h00001234, 0, 3, 1, 0, 0, "lh_06");
    access(0, 3'd2, 32'h04, 32'd0, 32'h12345678, 0, 3, 1, 0, 0, "lw_04");
    access(1, 3'd2, 32'h04, 32'h000080FF, 32'd0, 0, 2, 0, 1, 0, "sw_w1b");
    access(0, 3'd0, 32'h04, 32'd0, 32'hFFFFFFFF, 0, 3, 1, 0, 0, "lb_04");
    access(0, 3'd4, 32'h04, 32'd0, 32'h000000FF, 0, 3, 1, 0, 0, "lbu_04");
    access(0, 3'd1, 32'h04, 32'd0, 32'hFFFF80FF, 0, 3, 1, 0, 0, "lh_04");
    access(0, 3'd5, 32'h04, 32'd0, 32'h000080FF, 0, 3, 1, 0, 0, "lhu_04");

    access(1, 3'd2, 32'h08, 32'hAABBCCDD, 32'd0, 0, 2, 0, 1, 0, "sw_w2");
    access(1, 3'd0, 32'h09, 32'h00000011, 32'd0, 0, 4, 1, 1, 0, "sb_09");
    chk("sb_09_waddr", {27'd0, last_waddr}, 32'd2);
    chk("sb_09_wdata", last_wdata, 32'hAABB11DD);
    access(1, 3'd1, 32'h0A, 32'hFFFF5566, 32'd0, 0, 4, 1, 1, 0, "sh_0a");
    access(0, 3'd2, 32'h08, 32'd0, 32'h556611DD, 0, 3, 1, 0, 0, "lw_08");
    access(1, 3'd2, 32'h84, 32'h0BADBEEF, 32'd0, 0, 2, 0, 1, 0, "sw_wrap");
    chk("sw_wrap_waddr", {27'd0, last_waddr}, 32'd1);

    access(0, 3'd3, 32'h04, 32'd0, 32'd0, 1, 1, 0, 0, 0, "bad_f3_3");
    access(1, 3'd4, 32'h04, 32'd0, 32'd0, 1, 1, 0, 0, 0, "bad_sbu");
    access(0, 3'd7, 32'h04, 32'd0, 32'd0, 1, 1, 0, 0, 0, "bad_f3_7");
`ifdef LSU_MISALIGN_TRAP_EN
    access(0, 3'd2, 32'h02, 32'd0, 32'd0, 1, 1, 0, 0, 0, "lw_02");
    access(0, 3'd1, 32'h05, 32'd0, 32'd0, 1, 1, 0, 0, 0, "lh_05");
`else
    access(0, 3'd2, 32'h02, 32'd0, 32'hCAFEF00D, 0, 3, 1, 0, 0, "lw_02");
    access(0, 3'd1, 32'h05, 32'd0, 32'hFFFFBEEF, 0, 3, 1, 0, 0, "lh_05");
`endif
    access(0, 3'd2, 32'h08, 32'd0, 32'h556611DD, 0, 3, 1, 0, 5, "lw_hold");

    // Reset while an SB sits in CAP, one cycle before its write
    begin
      int wr0;
      wr0 = wr_cnt;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd0;
      bus.req_addr = 32'h00; bus.req_wdata = 32'h00000099;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_mid_write", {31'd0, bus.mem_write}, 32'd0);
      rst = 1'b0;
      repeat (4) begin
        @(negedge clk);
        chk("rst_mid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      end
      chk("rst_mid_writes", wr_cnt - wr0, 32'd0);
      chk("rst_mid_mem0", mem[0], 32'hCAFEF00D);
    end
    access(0, 3'd2, 32'h00, 32'd0, 32'hCAFEF00D, 0, 3, 1, 0, 0, "lw_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
